// File: rtl/csr.sv
// csr: one Zicsr control/status register with a direct external write port.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous active-high reset, loads ResetValue
//   csr_enable       current instruction is a CSR instruction
//   csr_addr         CSR address carried by the instruction
//   rs1_data         operand for CSRRW / CSRRS / CSRRC
//   rs1_zimm         5-bit immediate for CSRRWI / CSRRSI / CSRRCI
//   csr_op           decoded CSR operation
//   ext_data         external write data (CsrWidth bits)
//   ext_write_enable external write strobe, loses to an instruction write
//   out              pre-update register value when addressed, else 0

package decoder_pkg;
    typedef logic [31:0] word;
    typedef logic [11:0] csr_addr_t;
    typedef logic [4:0]  r;
    // funct3 encoding: bit 2 selects the immediate form, bits 1:0 the action
    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_op_t;
endpackage

module csr
    import decoder_pkg::*;
#(
    parameter csr_addr_t           Addr       = 12'h000,
    parameter int                  CsrWidth   = 32,
    parameter logic [CsrWidth-1:0] ResetValue = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                csr_enable,
    input  csr_addr_t           csr_addr,
    input  word                 rs1_data,
    input  r                    rs1_zimm,
    input  csr_op_t             csr_op,
    input  logic [CsrWidth-1:0] ext_data,
    input  logic                ext_write_enable,
    output word                 out
);
    logic [CsrWidth-1:0] value;
    logic [CsrWidth-1:0] operand;
    logic [CsrWidth-1:0] inst_value;
    logic [1:0]          action;
    logic                match;
    logic                inst_write;
    word                 operand_w;

    always_comb begin
        match      = csr_addr == Addr;
        action     = csr_op[1:0];
        operand_w  = csr_op[2] ? {27'b0, rs1_zimm} : rs1_data;
        operand    = operand_w[CsrWidth-1:0];
        // action 2'b00 is not a legal CSR op, so it never writes
        inst_write = csr_enable && match && action != 2'b00;
        inst_value = action == 2'b01 ? operand :
                     action == 2'b10 ? (value | operand) :
                                       (value & ~operand);
        out        = match ? word'(value) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            value <= ResetValue;
        else if (inst_write)
            value <= inst_value;
        else if (ext_write_enable)
            value <= ext_data;
    end
endmodule

// File: tb/tb_csr.sv
// tb_csr: directed and randomized checks of csr against a behavioural model.
module tb_csr;
    import decoder_pkg::*;

    logic      clk = 1'b0;
    logic      reset = 1'b0;
    logic      csr_enable = 1'b0;
    csr_addr_t csr_addr = '0;
    word       rs1_data = '0;
    r          rs1_zimm = '0;
    csr_op_t   csr_op = CSRRW;
    word       ext_data = '0;
    logic      ext_write_enable = 1'b0;
    word       out0;
    word       out1;

    int tests = 0;
    int fails = 0;

    // model state: u0 is default 32-bit @0x000, u1 is 8-bit @0x300 resetting to 0x5A
    word  m0;
    logic [7:0] m1;
    bit   model_valid = 0;

    csr u0 (
        .clk(clk), .reset(reset), .csr_enable(csr_enable), .csr_addr(csr_addr),
        .rs1_data(rs1_data), .rs1_zimm(rs1_zimm), .csr_op(csr_op),
        .ext_data(ext_data), .ext_write_enable(ext_write_enable), .out(out0)
    );

    csr #(.Addr(12'h300), .CsrWidth(8), .ResetValue(8'h5A)) u1 (
        .clk(clk), .reset(reset), .csr_enable(csr_enable), .csr_addr(csr_addr),
        .rs1_data(rs1_data), .rs1_zimm(rs1_zimm), .csr_op(csr_op),
        .ext_data(ext_data[7:0]), .ext_write_enable(ext_write_enable), .out(out1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input word got, input word exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic word operand_of(input csr_op_t op, input word rs1, input r zimm);
        return (op inside {CSRRWI, CSRRSI, CSRRCI}) ? word'(zimm) : rs1;
    endfunction

    function automatic word apply(input word cur, input csr_op_t op, input word v);
        case (op)
            CSRRW, CSRRWI: return v;
            CSRRS, CSRRSI: return cur | v;
            CSRRC, CSRRCI: return cur & ~v;
            default:       return cur;
        endcase
    endfunction

    function automatic word exp0();
        return (csr_addr == 12'h000) ? m0 : 32'h0;
    endfunction

    function automatic word exp1();
        return (csr_addr == 12'h300) ? {24'h0, m1} : 32'h0;
    endfunction

    // Apply one cycle of inputs: check the combinational (old) read value,
    // clock it, advance the model, then check the updated value.
    task automatic step(input string tag, input logic rst, input logic en, input csr_addr_t a,
                        input csr_op_t op, input word rs1, input r zimm,
                        input logic ewe, input word ext);
        word v;
        reset = rst; csr_enable = en; csr_addr = a; csr_op = op;
        rs1_data = rs1; rs1_zimm = zimm; ext_write_enable = ewe; ext_data = ext;
        #1;
        if (model_valid) begin
            chk({tag, "_pre0"}, out0, exp0());
            chk({tag, "_pre1"}, out1, exp1());
        end
        v = operand_of(op, rs1, zimm);
        if (rst) begin
            m0 = 32'h0;
            m1 = 8'h5A;
            model_valid = 1;
        end else begin
            if (en && a == 12'h000) m0 = apply(m0, op, v);
            else if (ewe)           m0 = ext;
            if (en && a == 12'h300) m1 = 8'(apply({24'h0, m1}, op, v));
            else if (ewe)           m1 = ext[7:0];
        end
        @(posedge clk);
        #1;
        if (model_valid) begin
            chk({tag, "_post0"}, out0, exp0());
            chk({tag, "_post1"}, out1, exp1());
        end
    endtask

    initial begin
        csr_op_t ops [6] = '{CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI};
        @(posedge clk);
        #1;
        step("reset", 1, 0, 12'h000, CSRRW, 32'h0, 5'd0, 0, 32'h0);
        chk("reset_out", out0, 32'h0);
        reset = 0; csr_enable = 1; csr_op = CSRRW; rs1_data = 32'hB;
        #1;
        chk("csrrw_old", out0, 32'h0);
        step("csrrw", 0, 1, 12'h000, CSRRW, 32'hB, 5'd0, 0, 32'h0);
        chk("csrrw_new", out0, 32'hB);
        step("csrrs", 0, 1, 12'h000, CSRRS, 32'hC, 5'd0, 0, 32'h0);
        chk("csrrs_new", out0, 32'hF);
        step("csrrc", 0, 1, 12'h000, CSRRC, 32'hC, 5'd0, 0, 32'h0);
        chk("csrrc_new", out0, 32'h3);
        step("csrrwi", 0, 1, 12'h000, CSRRWI, 32'hFFFF, 5'd1, 0, 32'h0);
        chk("csrrwi_new", out0, 32'h1);
        step("csrrsi", 0, 1, 12'h000, CSRRSI, 32'hFFFF, 5'd2, 0, 32'h0);
        chk("csrrsi_new", out0, 32'h3);
        step("csrrci", 0, 1, 12'h000, CSRRCI, 32'hFFFF, 5'd1, 0, 32'h0);
        chk("csrrci_new", out0, 32'h2);
        step("set_zero", 0, 1, 12'h000, CSRRS, 32'h0, 5'd0, 0, 32'h0);
        chk("set_zero_new", out0, 32'h2);
        csr_enable = 0; csr_addr = 12'h001;
        #1;
        chk("miss_same_cycle", out0, 32'h0);
        step("miss_write", 0, 1, 12'h001, CSRRW, 32'hFF, 5'd0, 0, 32'h0);
        chk("miss_write_out", out0, 32'h0);
        step("back_hit", 0, 0, 12'h000, CSRRW, 32'h0, 5'd0, 0, 32'h0);
        chk("miss_kept", out0, 32'h2);
        step("disabled", 0, 0, 12'h000, CSRRW, 32'h55, 5'd0, 0, 32'h0);
        chk("disabled_kept", out0, 32'h2);
        step("ext", 0, 0, 12'h000, CSRRW, 32'h0, 5'd0, 1, 32'hA5);
        chk("ext_new", out0, 32'hA5);
        step("ext_vs_inst", 0, 1, 12'h000, CSRRW, 32'h3C, 5'd0, 1, 32'h77);
        chk("inst_wins", out0, 32'h3C);
        step("rst_inst", 1, 1, 12'h000, CSRRW, 32'h99, 5'd0, 0, 32'h0);
        chk("rst_over_inst", out0, 32'h0);
        step("pre_rst_ext", 0, 1, 12'h000, CSRRW, 32'h12, 5'd0, 0, 32'h0);
        step("rst_ext", 1, 0, 12'h000, CSRRW, 32'h0, 5'd0, 1, 32'hDEAD);
        chk("rst_over_ext", out0, 32'h0);
        step("w8_trunc", 0, 1, 12'h300, CSRRW, 32'h1234_56C3, 5'd0, 0, 32'h0);
        chk("w8_trunc_out", out1, 32'hC3);
        for (int i = 0; i < 300; i++) begin
            int sel;
            csr_addr_t a;
            sel = $urandom_range(0, 9);
            a = sel < 4 ? 12'h000 : sel < 8 ? 12'h300 : csr_addr_t'($urandom);
            step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), a,
                 ops[$urandom_range(0, 5)], $urandom, r'($urandom),
                 ($urandom_range(0, 2) == 0), $urandom);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
